// File: rtl/instrument_axil_pkg.sv
// Shared types and constants for the Instrument AXI4-Lite register bank.
package instrument_axil_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned IDX_W    = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    typedef struct packed {
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
    } rd_rsp_t;

endpackage

// File: rtl/instrument_axil_if.sv
// AXI4-Lite channel bundle between the bus master and the register bank.
interface instrument_axil_if;
    import instrument_axil_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/instrument_axil_strb_merge.sv
// Bytewise merge of the current register value with write data under the byte strobes.
module instrument_axil_strb_merge
    import instrument_axil_pkg::*;
(
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] merged_c
);

    always_comb begin
        merged_c = old_data;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            if (wstrb[i]) merged_c[8*i +: 8] = wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/instrument_axil_regs.sv
// AXI4-Lite slave with four 32-bit R/W registers exported to the instrument datapath.
// Define INSTR_AXIL_SLVERR_EN to answer 0x10-0x1C with SLVERR instead of aliasing regs 0-3.
module instrument_axil_regs
    import instrument_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESETN,
    instrument_axil_if.slave           s00_axi,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        reg_wr_o
);

    if (C_S_AXI_DATA_WIDTH != DATA_W || C_S_AXI_ADDR_WIDTH != ADDR_W) begin : g_param_check
        $error("instrument_axil_regs supports only 32-bit data and 5-bit addresses");
    end

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic                              awready_q, awready_d;
    logic                              bvalid_q, bvalid_d;
    logic [1:0]                        bresp_q, bresp_d;
    logic                              arready_q, arready_d;
    logic                              rvalid_q, rvalid_d;
    rd_rsp_t                           rsp_q, rsp_d;
    logic [NUM_REGS-1:0]               reg_wr_q, reg_wr_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q;
    logic [DATA_W-1:0]                 merged_c;

    logic     wr_fire_c, rd_fire_c, wr_err_c, rd_err_c;
    reg_idx_t wr_idx_c, rd_idx_c;
    logic     unused_c;

    assign wr_idx_c  = reg_idx_t'(s00_axi.awaddr[3:2]);
    assign rd_idx_c  = reg_idx_t'(s00_axi.araddr[3:2]);
    assign wr_fire_c = awready_q & s00_axi.awvalid & s00_axi.wvalid;
    assign rd_fire_c = arready_q & s00_axi.arvalid;

`ifdef INSTR_AXIL_SLVERR_EN
    assign wr_err_c = s00_axi.awaddr[4];
    assign rd_err_c = s00_axi.araddr[4];
`else
    assign wr_err_c = 1'b0;
    assign rd_err_c = 1'b0;
`endif

    assign unused_c = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0],
                        s00_axi.araddr[1:0], s00_axi.awaddr[4], s00_axi.araddr[4]};

    instrument_axil_strb_merge u_strb_merge (
        .old_data (regs_q[wr_idx_c]),
        .wdata    (s00_axi.wdata),
        .wstrb    (s00_axi.wstrb),
        .merged_c (merged_c)
    );

    // Write FSM: READY pulses for one cycle once AW and W are both present.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        reg_wr_d  = '0;
        case (w_state_q)
            W_IDLE: begin
                if (wr_fire_c) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_err_c ? RESP_SLVERR : RESP_OKAY;
                    if (!wr_err_c) reg_wr_d[wr_idx_c] = 1'b1;
                end else if (s00_axi.awvalid && s00_axi.wvalid && !bvalid_q && !awready_q) begin
                    awready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (s00_axi.bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: RDATA samples the register bank on the ARREADY handshake edge.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rsp_d     = rsp_q;
        case (r_state_q)
            R_IDLE: begin
                if (rd_fire_c) begin
                    r_state_d  = R_DATA;
                    rvalid_d   = 1'b1;
                    rsp_d.resp = rd_err_c ? RESP_SLVERR : RESP_OKAY;
                    rsp_d.data = rd_err_c ? '0 : regs_q[rd_idx_c];
                end else if (s00_axi.arvalid && !rvalid_q && !arready_q) begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (s00_axi.rready) begin
                    r_state_d  = R_IDLE;
                    rvalid_d   = 1'b0;
                    rsp_d.resp = RESP_OKAY;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rsp_q     <= '0;
            reg_wr_q  <= '0;
            regs_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rsp_q     <= rsp_d;
            reg_wr_q  <= reg_wr_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (reg_wr_d[i]) regs_q[i] <= merged_c;
            end
        end
    end

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = awready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rsp_q.data;
    assign s00_axi.rresp   = rsp_q.resp;
    assign regs_o          = regs_q;
    assign reg_wr_o        = reg_wr_q;

endmodule

// File: tb/tb_instrument_axil_regs.sv
// Scoreboard bench for instrument_axil_regs; expectations follow INSTR_AXIL_SLVERR_EN when defined.
module tb_instrument_axil_regs;
    import instrument_axil_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [127:0] regs_o;
    logic [3:0]   reg_wr_o;

    instrument_axil_if axi ();

    instrument_axil_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s00_axi       (axi),
        .regs_o        (regs_o),
        .reg_wr_o      (reg_wr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    int wr_pulse_cnt[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every completed B or R handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (axi.bvalid && axi.bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 128'(axi.bresp), 128'hX);
                else chk("bresp", 128'(axi.bresp), 128'(exp_b.pop_front()));
            end
            if (axi.rvalid && axi.rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", 128'({axi.rresp, axi.rdata}), 128'hX);
                else chk("rresp_rdata", 128'({axi.rresp, axi.rdata}), 128'(exp_r.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (reg_wr_o[i] === 1'b1) wr_pulse_cnt[i]++;
    end

    task automatic clear_pulses();
        for (int i = 0; i < 4; i++) wr_pulse_cnt[i] = 0;
    endtask

    task automatic aw_issue(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        axi.awaddr  = addr;
        axi.wdata   = data;
        axi.wstrb   = strb;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
    endtask

    task automatic aw_wait_hs();
        bit hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            if (axi.awready && axi.wready) hs = 1'b1;
        end
        chk("aw_w_handshake", 128'(hs), 128'd1);
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
    endtask

    task automatic b_wait();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (axi.bvalid && axi.bready) done = 1'b1;
        end
        chk("b_complete", 128'(done), 128'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        exp_b.push_back(resp);
        aw_issue(addr, data, strb);
        aw_wait_hs();
        b_wait();
    endtask

    task automatic do_read(input logic [4:0] addr, input logic [31:0] data, input logic [1:0] resp);
        bit hs = 1'b0;
        bit done = 1'b0;
        exp_r.push_back({resp, data});
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            if (axi.arready) hs = 1'b1;
        end
        chk("ar_handshake", 128'(hs), 128'd1);
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (axi.rvalid && axi.rready) done = 1'b1;
        end
        chk("r_complete", 128'(done), 128'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [31:0] reg1_exp;

        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
        axi.araddr = '0; axi.arprot = 3'b101; axi.arvalid = 1'b0; axi.rready = 1'b1;
        clear_pulses();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_regs", regs_o, 128'h0);
        chk("reset_reg_wr", 128'(reg_wr_o), 128'h0);
        chk("reset_handshake", 128'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), 128'h0);
        chk("reset_resp_data", 128'({axi.bresp, axi.rresp, axi.rdata}), 128'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write / readback of all four registers
        do_write(5'h00, 32'h1, 4'hF, RESP_OKAY);
        do_write(5'h04, 32'h2, 4'hF, RESP_OKAY);
        do_write(5'h08, 32'h3, 4'hF, RESP_OKAY);
        do_write(5'h0C, 32'h4, 4'hF, RESP_OKAY);
        do_read(5'h00, 32'h1, RESP_OKAY);
        do_read(5'h04, 32'h2, RESP_OKAY);
        do_read(5'h08, 32'h3, RESP_OKAY);
        do_read(5'h0C, 32'h4, RESP_OKAY);
        chk("regs_after_fill", regs_o, 128'h00000004_00000003_00000002_00000001);

        // Partial strobe write and single-cycle reg_wr pulse
        clear_pulses();
        do_write(5'h08, 32'hAABBCCDD, 4'b0101, RESP_OKAY);
        chk("reg_wr2_pulses", 128'(wr_pulse_cnt[2]), 128'd1);
        chk("reg_wr_other_pulses", 128'(wr_pulse_cnt[0] + wr_pulse_cnt[1] + wr_pulse_cnt[3]), 128'd0);
        do_read(5'h08, 32'h00BB00DD, RESP_OKAY);

        // AW alone must not be accepted
        exp_b.push_back(RESP_OKAY);
        axi.awaddr = 5'h00; axi.wdata = 32'h55; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (axi.awready || axi.wready) ok = 1'b0;
        end
        chk("aw_alone_no_ready", 128'(ok), 128'd1);
        @(posedge clk); #1;
        axi.wvalid = 1'b1;
        aw_wait_hs();
        b_wait();
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (axi.bvalid) ok = 1'b0;
        end
        chk("single_b_response", 128'(ok), 128'd1);
        @(posedge clk); #1;
        chk("reg0_after_split", 128'(regs_o[31:0]), 128'h55);

        // BREADY backpressure blocks the next write
        axi.bready = 1'b0;
        exp_b.push_back(RESP_OKAY);
        aw_issue(5'h0C, 32'h0C0C, 4'hF);
        aw_wait_hs();
        exp_b.push_back(RESP_OKAY);
        aw_issue(5'h00, 32'h77, 4'hF);
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (!axi.bvalid || axi.awready || axi.wready) ok = 1'b0;
        end
        chk("bvalid_held_no_accept", 128'(ok), 128'd1);
        @(posedge clk); #1;
        axi.bready = 1'b1;
        aw_wait_hs();
        b_wait();

        // Concurrent read and write of register 1: read sees the pre-write value
        fork
            do_write(5'h04, 32'h0000DEAD, 4'hF, RESP_OKAY);
            do_read(5'h04, 32'h2, RESP_OKAY);
        join
        do_read(5'h04, 32'h0000DEAD, RESP_OKAY);

        // Unmapped region
        clear_pulses();
`ifdef INSTR_AXIL_SLVERR_EN
        do_write(5'h14, 32'hFFFFFFFF, 4'hF, RESP_SLVERR);
        chk("unmapped_no_pulse", 128'(wr_pulse_cnt[0] + wr_pulse_cnt[1] + wr_pulse_cnt[2] + wr_pulse_cnt[3]), 128'd0);
        do_read(5'h14, 32'h0, RESP_SLVERR);
        reg1_exp = 32'h0000DEAD;
`else
        do_write(5'h14, 32'h0000BEEF, 4'hF, RESP_OKAY);
        chk("alias_reg1_pulse", 128'(wr_pulse_cnt[1]), 128'd1);
        do_read(5'h14, 32'h0000BEEF, RESP_OKAY);
        do_read(5'h04, 32'h0000BEEF, RESP_OKAY);
        reg1_exp = 32'h0000BEEF;
`endif
        chk("regs_final", regs_o, {32'h00000C0C, 32'h00BB00DD, reg1_exp, 32'h00000077});

        // Reset while a B response is pending
        axi.bready = 1'b0;
        exp_b.push_back(RESP_OKAY);
        aw_issue(5'h08, 32'h1, 4'hF);
        aw_wait_hs();
        @(negedge clk);
        chk("bvalid_before_reset", 128'(axi.bvalid), 128'd1);
        rst_n = 1'b0;
        #2;
        chk("bvalid_after_reset", 128'(axi.bvalid), 128'd0);
        chk("regs_after_reset", regs_o, 128'h0);
        exp_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
        axi.bready = 1'b1;
        @(posedge clk); #1;
        do_read(5'h08, 32'h0, RESP_OKAY);

        repeat (3) @(posedge clk);
        chk("b_queue_drained", 128'(exp_b.size()), 128'd0);
        chk("r_queue_drained", 128'(exp_r.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instrument_axil_regs.md
# instrument_axil_regs

AXI4-Lite slave register bank for the Instrument IP. It responds to the 32-bit AXI4-Lite master on the S00_AXI port and holds four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC. The register contents and a per-register write strobe are exported to the instrument datapath. Write and read channels run independently, with one outstanding transaction per direction.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width. Address bits [3:2] select the register; bit 4 marks the unmapped region 0x10–0x1C.
- S_AXI_ACLK  in  1  the single clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  accepted and ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  accepted and ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- regs_o  out  128  register contents; reg n occupies bits [32n+31:32n].
- reg_wr_o  out  4  one-cycle pulse per register on each accepted write, asserted even if WSTRB=0.

## Operation
**Write path.** States are W_IDLE and W_RESP.
- W_IDLE: when AWVALID, WVALID and !BVALID are all high, assert AWREADY and WREADY together for exactly one cycle.
- In that same cycle, update the addressed register bytewise under WSTRB, pulse reg_wr_o[AWADDR[3:2]], and go to W_RESP.
- If only one of AWVALID or WVALID is high, do nothing and keep both READYs low.
- W_RESP: BVALID is high and BRESP is held stable until BREADY is seen, then return to W_IDLE. The earliest next AW/W acceptance is the cycle after BVALID falls.

**Read path.** States are R_IDLE and R_DATA.
- R_IDLE: when ARVALID and !RVALID are high, pulse ARREADY for one cycle.
- On the following clock edge, load RDATA from the selected register (or 0 when unmapped), set RRESP, raise RVALID and go to R_DATA.
- R_DATA: RDATA, RRESP and RVALID are held until RREADY, then return to R_IDLE.

**Simultaneous events.**
- A read and a write may complete in the same cycle.
- If a write updates the register being latched into RDATA in the same edge, RDATA returns the pre-write value.

**Unmapped addresses** (ADDR[4]=1): behaviour depends on the configuration below. AxADDR[1:0] are ignored.

## Timing
- Reset values: all registers 0, regs_o 0, reg_wr_o 0, AWREADY/WREADY/ARREADY 0, BVALID/RVALID 0, BRESP/RRESP 00, RDATA 0. Both FSMs start in IDLE.
- Write latency: with AW and W valid at edge N, READYs are high in cycle N and BVALID is high in cycle N+1. regs_o reflects the new value from cycle N+1.
- Read latency: ARREADY is high in cycle N, RVALID is high in cycle N+1.
- Throughput: one write every 3 cycles and one read every 3 cycles when the master holds BREADY/RREADY high.
- Reset mid-transaction: asserting S_AXI_ARESETN low immediately clears all state. A pending B or R response is dropped.
- The slave never drops VALID before the handshake, and never changes RDATA or BRESP while VALID is high.

## Configuration
- INSTR_AXIL_SLVERR_EN defined:
  - Unmapped writes are accepted, leave every register unchanged, do not pulse reg_wr_o, and return BRESP=10 (SLVERR).
  - Unmapped reads return RDATA=0 with RRESP=10.
- INSTR_AXIL_SLVERR_EN undefined:
  - ADDR[4] is ignored, so 0x10–0x1C alias registers 0–3.
  - BRESP and RRESP are always 00.

## Structure
- Package instrument_axil_pkg holds:
  - the response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - NUM_REGS=4;
  - the register index type (2 bits);
  - the write and read FSM state enums.
- One sub-module, instrument_axil_strb_merge, computes the bytewise merge of old data, WDATA and WSTRB. It is purely combinational.

## Test plan
- Reset, then write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC and read each back → RDATA equals 0x1–0x4 with RRESP=00; regs_o = 0x00000004_00000003_00000002_00000001.
- Write 0xAABBCCDD to 0x8 with WSTRB=0101 over an old value of 0x00000003 → reads back 0x00BB00DD; reg_wr_o[2] pulses for exactly one cycle.
- Present AWVALID alone for 5 cycles, then WVALID → no READY until both are valid; a single response follows.
- Hold BREADY low for 4 cycles after a write → BVALID stays high; a second AW/W presented meanwhile is not accepted until B completes.
- Issue a read of 0x4 in the same cycle as a write of 0xDEAD to 0x4 → RDATA returns the old value; a subsequent read returns 0x0000DEAD.
- Address 0x14:
  - with INSTR_AXIL_SLVERR_EN: a write gives BRESP=10 with register 1 unchanged, and a read gives RDATA=0 with RRESP=10;
  - without it: the access aliases register 1.
